// File: rtl/stream_packetizer.sv
// stream_packetizer: groups a ready/valid byte stream into packets of a
// programmable payload length. Each packet ends with a trailer beat
// {seq, cnt} flagged by m_last. A packet is also closed early after
// TIMEOUT starved cycles. A single output register carries both payload
// and generated beats.
//
// Optional feature macro: STREAM_PACKETIZER_CHECKSUM_EN
//   When defined, an XOR-checksum beat is inserted between the last
//   payload beat and the trailer.
//
// state  | meaning
// -------+------------------------------------------------
// IDLE   | no payload held, waiting for the first beat
// FILL   | 1..len-1 payload beats accepted
// CSUM   | checksum beat pending (checksum build only)
// TRAIL  | trailer beat pending
module stream_packetizer #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LEN    = 15,
    parameter int TIMEOUT    = 32,
    localparam int CW        = $clog2(MAX_LEN + 1),
    localparam int SW        = DATA_WIDTH - CW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CW-1:0]         cfg_len,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [15:0]           pkt_cnt,
    output logic                  busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
        ST_CSUM  = 2'd2,
`endif
        ST_TRAIL = 2'd3
    } state_t;

    // First state entered once the payload of a packet is complete.
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
    localparam state_t ST_CLOSE = ST_CSUM;
`else
    localparam state_t ST_CLOSE = ST_TRAIL;
`endif

    state_t                state_q,   state_d;
    logic [CW-1:0]         cnt_q,     cnt_d;
    logic [CW-1:0]         len_q,     len_d;
    logic [SW-1:0]         seq_q,     seq_d;
    logic [TW-1:0]         tmr_q,     tmr_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q,  m_last_d;
    logic [DATA_WIDTH-1:0] m_data_q,  m_data_d;
    logic [15:0]           pkt_cnt_q, pkt_cnt_d;
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] acc_q,     acc_d;
`endif

    logic          out_free;
    logic          in_hs;
    logic          close_req;
    logic [CW-1:0] cfg_len_eff;
    logic [CW-1:0] len_use;
    logic [CW-1:0] cnt_inc;

    assign out_free    = !m_valid_q || m_ready;
    assign s_ready     = (state_q == ST_IDLE || state_q == ST_FILL) && out_free;
    assign in_hs       = s_valid && s_ready;
    assign cfg_len_eff = (cfg_len == '0 || cfg_len > CW'(MAX_LEN)) ? CW'(MAX_LEN) : cfg_len;
    // The first beat of a packet compares against the freshly sampled length.
    assign len_use     = (state_q == ST_IDLE) ? cfg_len_eff : len_q;
    assign cnt_inc     = cnt_q + CW'(1);

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign pkt_cnt = pkt_cnt_q;
    assign busy    = (state_q != ST_IDLE) || m_valid_q;

    // Next-state, output-register and timer logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        seq_d     = seq_q;
        tmr_d     = tmr_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        pkt_cnt_d = pkt_cnt_q;
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
        acc_d     = acc_q;
`endif
        close_req = 1'b0;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            if (m_last_q) begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
        end

        if (in_hs) begin
            m_valid_d = 1'b1;
            m_data_d  = s_data;
            m_last_d  = 1'b0;
            cnt_d     = cnt_inc;
            tmr_d     = TW'(TIMEOUT);
            if (state_q == ST_IDLE) begin
                len_d = cfg_len_eff;
            end
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
            acc_d = (state_q == ST_IDLE) ? s_data : (acc_q ^ s_data);
`endif
            state_d = (cnt_inc == len_use) ? ST_CLOSE : ST_FILL;
        end else begin
            case (state_q)
                ST_FILL: begin
                    // Only true starvation counts; a stalled valid beat holds the timer.
                    if (!s_valid) begin
                        if (tmr_q == TW'(1)) begin
                            close_req = 1'b1;
                        end else begin
                            tmr_d = tmr_q - TW'(1);
                        end
                    end
                end
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
                ST_CSUM:  close_req = 1'b1;
`endif
                ST_TRAIL: close_req = 1'b1;
                default:  ;
            endcase
        end

        // A timeout emits its closing beat in the same cycle when the
        // register is free, so the trailer follows the last starved cycle.
        if (close_req) begin
            if (!out_free) begin
                if (state_q == ST_FILL) begin
                    state_d = ST_CLOSE;
                end
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
            end else if (state_q != ST_TRAIL) begin
                m_valid_d = 1'b1;
                m_data_d  = acc_q;
                m_last_d  = 1'b0;
                state_d   = ST_TRAIL;
`endif
            end else begin
                m_valid_d = 1'b1;
                m_data_d  = {seq_q, cnt_q};
                m_last_d  = 1'b1;
                seq_d     = seq_q + SW'(1);
                cnt_d     = '0;
                state_d   = ST_IDLE;
            end
        end
    end

    // State and output registers; reset discards any partial packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            seq_q     <= '0;
            tmr_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            pkt_cnt_q <= '0;
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
            acc_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            seq_q     <= seq_d;
            tmr_q     <= tmr_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
            pkt_cnt_q <= pkt_cnt_d;
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
            acc_q     <= acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_stream_packetizer.sv
// Testbench for stream_packetizer: directed scenarios plus a randomized
// phase, all checked against a packet-level reference model.
module tb_stream_packetizer;

    localparam int MAXL = 15;
    localparam int TO   = 32;
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic [3:0]  cfg_len = 4'd4;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data  = 8'h00;
    logic        s_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_ready = 1'b1;
    logic [15:0] pkt_cnt;
    logic        busy;

    int errors  = 0;
    int checks  = 0;
    int cyc     = 0;
    int last_hs = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stream_packetizer #(.DATA_WIDTH(8), .MAX_LEN(MAXL), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_len (cfg_len),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_ready (m_ready),
        .pkt_cnt (pkt_cnt),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model (packet level) ----------------
    logic [8:0] exp_q[$];
    bit         mdl_open   = 0;
    int         mdl_cnt    = 0;
    int         mdl_len    = 0;
    int         mdl_starve = 0;
    logic [3:0] mdl_seq    = 4'd0;
    logic [7:0] mdl_acc    = 8'h00;
    int         mdl_pkts   = 0;
    bit         prev_hs    = 0;
    logic [7:0] prev_data  = 8'h00;
    logic [8:0] mon_e;

    function automatic int eff_len(input logic [3:0] c);
        return (c == 0 || c > MAXL) ? MAXL : int'(c);
    endfunction

    task automatic mdl_close();
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
        exp_q.push_back({1'b0, mdl_acc});
`endif
        exp_q.push_back({1'b1, mdl_seq, 4'(mdl_cnt)});
        mdl_seq  = mdl_seq + 4'd1;
        mdl_open = 0;
    endtask

    // Monitor: compares every accepted output beat and tracks the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            mdl_open = 0;
            mdl_cnt  = 0;
            mdl_seq  = 4'd0;
            mdl_pkts = 0;
            prev_hs  = 0;
        end else begin
            if (prev_hs) begin
                chk("lat_valid", m_valid, 1);
                chk("lat_data", m_data, prev_data);
            end
            chk("busy", busy, (mdl_open || exp_q.size() != 0));
            if (m_valid && !m_ready) chk("rdy_bp", s_ready, 0);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", m_valid, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat", {m_last, m_data}, mon_e);
                    if (mon_e[8]) begin
                        chk("pkt_cnt", pkt_cnt, mdl_pkts);
                        mdl_pkts++;
                    end
                end
            end
            prev_hs   = s_valid && s_ready;
            prev_data = s_data;
            if (s_valid && s_ready) begin
                if (!mdl_open) begin
                    mdl_open = 1;
                    mdl_cnt  = 0;
                    mdl_len  = eff_len(cfg_len);
                    mdl_acc  = 8'h00;
                end
                exp_q.push_back({1'b0, s_data});
                mdl_cnt++;
                mdl_acc    = mdl_acc ^ s_data;
                mdl_starve = 0;
                if (mdl_cnt == mdl_len) mdl_close();
            end else if (mdl_open && !s_valid) begin
                mdl_starve++;
                if (mdl_starve == TO) mdl_close();
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_data  = b;
        @(negedge clk);
        while (!s_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("send_rdy", s_ready, 1);
        last_hs = cyc;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_trailer(output int c, output logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!(m_valid && m_last && m_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("trl_seen", m_valid && m_last, 1);
        c = cyc;
        d = m_data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         c;
        logic [7:0] d;
        int         burst;

        // Basic 4-beat packets back to back.
        do_reset();
        cfg_len = 4'd4;
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        wait_trailer(c, d);
        chk("t1_trl_lat", c - last_hs, 2 + EXTRA);
        chk("t1_trl", d, 8'h04);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        wait_trailer(c, d);
        chk("t1_trl2", d, 8'h14);
        tick();
        @(negedge clk);
        chk("t1_pkt_cnt", pkt_cnt, 2);
        tick();

        // Starvation timeout closes a 2-beat partial packet.
        do_reset();
        cfg_len = 4'd8;
        send(8'hA0); send(8'hA1);
        wait_trailer(c, d);
        chk("t2_to_lat", c - last_hs, TO + 1 + EXTRA);
        chk("t2_trl", d, 8'h02);

        // Long downstream stall mid-packet: input held, no timeout, no loss.
        cfg_len = 4'd4;
        send(8'h51); send(8'h52);
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h53;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("t3_hold_rdy", s_ready, 0);
            chk("t3_hold_data", m_data, 8'h52);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        send(8'h53); send(8'h54);
        wait_trailer(c, d);
        chk("t3_trl", d, 8'h14);

        // cfg_len 0 means MAX_LEN; a mid-packet change applies next packet.
        cfg_len = 4'd0;
        for (int i = 0; i < 15; i++) begin
            send(8'h60 + 8'(i));
            if (i == 2) cfg_len = 4'd2;
        end
        wait_trailer(c, d);
        chk("t4_trl_max", d, 8'h2F);
        send(8'h70); send(8'h71);
        wait_trailer(c, d);
        chk("t4_trl_two", d, 8'h32);

        // Seventeen single-beat packets: sequence wraps after 15.
        do_reset();
        cfg_len = 4'd1;
        for (int i = 0; i < 17; i++) begin
            send(8'($urandom));
            wait_trailer(c, d);
            chk("t5_trl", d, ((i % 16) << 4) | 1);
        end
        tick();
        @(negedge clk);
        chk("t5_pkt_cnt", pkt_cnt, 17);
        tick();

        // Reset mid-packet discards it and restarts the sequence.
        cfg_len = 4'd4;
        send(8'h11); send(8'h22); send(8'h33);
        do_reset();
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        wait_trailer(c, d);
        chk("t6_trl", d, 8'h04);

        // Randomized traffic with backpressure, starvation bursts and cfg changes.
        do_reset();
        burst = 0;
        for (int k = 0; k < 4000; k++) begin
            if (burst > 0) begin
                s_valid = 1'b0;
                burst--;
            end else begin
                if ($urandom_range(0, 99) < 2) burst = $urandom_range(25, 40);
                s_valid = ($urandom_range(0, 99) < 75);
            end
            s_data  = 8'($urandom);
            m_ready = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 49) == 0) cfg_len = 4'($urandom);
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (80) tick();
        @(negedge clk);
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
